draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_pkg.sv | 37 +++
 rtl/draw_scheduler_if.sv | 46 ++++
 rtl/draw_port_mux.sv | 55 +++++
 rtl/draw_scheduler.sv | 142 ++++++++++++++
 tb/tb_draw_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types, constants and helpers for the draw scheduler
//
// Holds the FSM state encoding, the requester index constants, the default
// coordinate/colour widths and the phase grant helper.
package draw_pkg;

   localparam int NUM_REQ   = 3;

   localparam int REQ_CLEAR = 0;
   localparam int REQ_WALL  = 1;
   localparam int REQ_BIRD  = 2;

   localparam int DEF_X_W   = 8;
   localparam int DEF_Y_W   = 7;
   localparam int DEF_C_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_P0,
      ST_P1,
      ST_P2,
      ST_FIN
   } state_t;

   // Grant vector for phase idx: one-hot when that requester asks and the
   // sequence is not frozen, otherwise zero (phase is skipped).
   function automatic logic [NUM_REQ-1:0] phase_grant(
      input logic [1:0]         idx,
      input logic [NUM_REQ-1:0] req,
      input logic               frz
   );
      logic [NUM_REQ-1:0] w_sel;
      w_sel = NUM_REQ'(1) << idx;
      return frz ? '0 : (w_sel & req);
   endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - request/grant and shared VGA port bundle
//
// i_* signals are inputs of the scheduler, o_* are its outputs.
// Modports: master (requesters / test driver), slave (draw_scheduler).
interface draw_scheduler_if
   import draw_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W,
   parameter int C_W = DEF_C_W
);

   logic                     i_frame_tick;
   logic                     i_freeze;
   logic [NUM_REQ-1:0]       i_req;
   logic [NUM_REQ-1:0]       i_done;
   logic [NUM_REQ*X_W-1:0]   i_x_in;
   logic [NUM_REQ*Y_W-1:0]   i_y_in;
   logic [NUM_REQ*C_W-1:0]   i_colour_in;
   logic [NUM_REQ-1:0]       i_plot_in;

   logic [NUM_REQ-1:0]       o_grant;
   logic [X_W-1:0]           o_vga_x;
   logic [Y_W-1:0]           o_vga_y;
   logic [C_W-1:0]           o_vga_colour;
   logic                     o_vga_plot;
   logic                     o_busy;
   logic                     o_frame_done;
   logic                     o_overrun;
   logic                     o_timeout;

   modport master (
      output i_frame_tick, i_freeze, i_req, i_done,
             i_x_in, i_y_in, i_colour_in, i_plot_in,
      input  o_grant, o_vga_x, o_vga_y, o_vga_colour, o_vga_plot,
             o_busy, o_frame_done, o_overrun, o_timeout
   );

   modport slave (
      input  i_frame_tick, i_freeze, i_req, i_done,
             i_x_in, i_y_in, i_colour_in, i_plot_in,
      output o_grant, o_vga_x, o_vga_y, o_vga_colour, o_vga_plot,
             o_busy, o_frame_done, o_overrun, o_timeout
   );

endinterface

// File: rtl/draw_port_mux.sv
// rtl/draw_port_mux.sv - shared VGA write port multiplexer and output register
//
// Ports: i_clk, i_reset (async, active-high), i_grant (one-hot or zero),
// i_x_in/i_y_in/i_colour_in/i_plot_in (packed per-requester slices),
// o_vga_x/o_vga_y/o_vga_colour/o_vga_plot (registered, 1-cycle latency).
module draw_port_mux
   import draw_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W,
   parameter int C_W = DEF_C_W
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [NUM_REQ-1:0]       i_grant,
   input  logic [NUM_REQ*X_W-1:0]   i_x_in,
   input  logic [NUM_REQ*Y_W-1:0]   i_y_in,
   input  logic [NUM_REQ*C_W-1:0]   i_colour_in,
   input  logic [NUM_REQ-1:0]       i_plot_in,
   output logic [X_W-1:0]           o_vga_x,
   output logic [Y_W-1:0]           o_vga_y,
   output logic [C_W-1:0]           o_vga_colour,
   output logic                     o_vga_plot
);

   logic [1:0] w_idx;
   logic       w_any;

   always_comb begin
      w_idx = 2'd0;
      w_any = |i_grant;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_grant[i]) w_idx = 2'(i);
      end
   end

   // Coordinates hold their last value while nobody owns the port so the
   // frame buffer never sees a spurious address change; only plot drops.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_vga_x      <= '0;
         o_vga_y      <= '0;
         o_vga_colour <= '0;
         o_vga_plot   <= 1'b0;
      end else if (w_any) begin
         o_vga_x      <= i_x_in[w_idx*X_W +: X_W];
         o_vga_y      <= i_y_in[w_idx*Y_W +: Y_W];
         o_vga_colour <= i_colour_in[w_idx*C_W +: C_W];
         o_vga_plot   <= i_plot_in[w_idx];
      end else begin
         o_vga_plot   <= 1'b0;
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - frame redraw sequencer granting the shared VGA port
//
// Ports: i_clk, i_reset (async, active-high), bus (draw_scheduler_if.slave):
// frame_tick/freeze/req/done/x/y/colour/plot in; grant, vga_*, busy,
// frame_done, overrun, timeout out.
// Optional: define DRAW_TIMEOUT_EN to build the grant watchdog
// (TIMEOUT_CYCLES cycles); otherwise o_timeout is tied low.
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int X_W            = DEF_X_W,
   parameter int Y_W            = DEF_Y_W,
   parameter int C_W            = DEF_C_W,
   parameter int TIMEOUT_CYCLES = 32768
) (
   input  logic               i_clk,
   input  logic               i_reset,
   draw_scheduler_if.slave    bus
);

   state_t             r_state;
   logic               r_freeze_q;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_busy;
   logic               r_frame_done;
   logic               r_overrun;

   logic               w_done_hit;
   logic               w_wd_hit;
   logic               w_adv;
   logic [1:0]         w_phase;

`ifdef DRAW_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0]    r_wdog;
   logic               r_timeout;

   // r_wdog counts completed granted cycles; the last one fires the watchdog.
   assign w_wd_hit = (r_grant != '0) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
   assign bus.o_timeout = r_timeout;
`else
   assign w_wd_hit = 1'b0;
   assign bus.o_timeout = 1'b0;
`endif

   // Only the done of the currently granted requester counts.
   assign w_done_hit = |(r_grant & bus.i_done);
   // A phase with no grant is a skipped phase and lasts exactly one cycle.
   assign w_adv = (r_grant == '0) || w_done_hit || w_wd_hit;

   always_comb begin
      w_phase = 2'(REQ_CLEAR);
      case (r_state)
         ST_P1:   w_phase = 2'(REQ_WALL);
         ST_P2:   w_phase = 2'(REQ_BIRD);
         default: w_phase = 2'(REQ_CLEAR);
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_freeze_q   <= 1'b0;
         r_grant      <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
         r_wdog       <= '0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         r_overrun    <= bus.i_frame_tick && (r_state != ST_IDLE);
`ifdef DRAW_TIMEOUT_EN
         r_timeout    <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (bus.i_frame_tick) begin
                  r_state    <= ST_P0;
                  r_freeze_q <= bus.i_freeze;
                  r_busy     <= 1'b1;
                  // freeze_q is only being latched now, so use the live value.
                  r_grant    <= phase_grant(2'(REQ_CLEAR), bus.i_req, bus.i_freeze);
               end
            end
            ST_P0, ST_P1, ST_P2: begin
               if (w_adv) begin
                  if (r_state == ST_P2) begin
                     r_state      <= ST_FIN;
                     r_grant      <= '0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_state <= (r_state == ST_P0) ? ST_P1 : ST_P2;
                     r_grant <= phase_grant(w_phase + 2'd1, bus.i_req, r_freeze_q);
                  end
`ifdef DRAW_TIMEOUT_EN
                  r_wdog    <= '0;
                  r_timeout <= w_wd_hit && !w_done_hit;
               end else begin
                  r_wdog    <= r_wdog + 1'b1;
`endif
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_grant      = r_grant;
   assign bus.o_busy       = r_busy;
   assign bus.o_frame_done = r_frame_done;
   assign bus.o_overrun    = r_overrun;

   draw_port_mux #(
      .X_W (X_W),
      .Y_W (Y_W),
      .C_W (C_W)
   ) u_port_mux (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_grant      (r_grant),
      .i_x_in       (bus.i_x_in),
      .i_y_in       (bus.i_y_in),
      .i_colour_in  (bus.i_colour_in),
      .i_plot_in    (bus.i_plot_in),
      .o_vga_x      (bus.o_vga_x),
      .o_vga_y      (bus.o_vga_y),
      .o_vga_colour (bus.o_vga_colour),
      .o_vga_plot   (bus.o_vga_plot)
   );

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - randomized self-checking bench for draw_scheduler
module tb_draw_scheduler;
   import draw_pkg::*;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;
   localparam int TO  = 16;
   localparam int XW3 = 3 * X_W;
   localparam int YW3 = 3 * Y_W;
   localparam int CW3 = 3 * C_W;
`ifdef DRAW_TIMEOUT_EN
   localparam int HOLD = TO;
`else
   localparam int HOLD = 1000;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   draw_scheduler_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();

   draw_scheduler #(
      .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model of the shared write port
   logic [X_W-1:0] m_vx;
   logic [Y_W-1:0] m_vy;
   logic [C_W-1:0] m_vc;
   logic           m_vp;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs(input logic [2:0] g, input bit b, input bit fd,
                                input bit ov, input bit to);
      check_eq("grant",      32'(bus.o_grant),      32'(g));
      check_eq("busy",       32'(bus.o_busy),       32'(b));
      check_eq("frame_done", 32'(bus.o_frame_done), 32'(fd));
      check_eq("overrun",    32'(bus.o_overrun),    32'(ov));
      check_eq("timeout",    32'(bus.o_timeout),    32'(to));
      check_eq("vga_plot",   32'(bus.o_vga_plot),   32'(m_vp));
      check_eq("vga_x",      32'(bus.o_vga_x),      32'(m_vx));
      check_eq("vga_y",      32'(bus.o_vga_y),      32'(m_vy));
      check_eq("vga_colour", 32'(bus.o_vga_colour), 32'(m_vc));
   endtask

   // Randomize requester payloads for this cycle and advance the port model:
   // whoever is granted this cycle appears on the port next cycle.
   task automatic drive_payload(input logic [2:0] g_now, input bit max_xy);
      bus.i_x_in      = XW3'($urandom);
      bus.i_y_in      = YW3'($urandom);
      bus.i_colour_in = CW3'($urandom);
      bus.i_plot_in   = 3'($urandom);
      if (max_xy && g_now == 3'b010) begin
         bus.i_x_in[X_W +: X_W]      = X_W'(159);
         bus.i_y_in[Y_W +: Y_W]      = Y_W'(119);
         bus.i_colour_in[C_W +: C_W] = C_W'(5);
         bus.i_plot_in[1]            = 1'b1;
      end
      m_vp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (g_now[i]) begin
            m_vx = bus.i_x_in[i*X_W +: X_W];
            m_vy = bus.i_y_in[i*Y_W +: Y_W];
            m_vc = bus.i_colour_in[i*C_W +: C_W];
            m_vp = bus.i_plot_in[i];
         end
      end
   endtask

   // One redraw sequence. d* = cycles from grant to done; ovr_at: 0 none,
   // -1 random cycle inside the sequence, >0 explicit cycle for a second tick.
   task automatic run_frame(input logic [2:0] req, input bit frz,
                            input int d0, input int d1, input int d2,
                            input int ovr_at, input bit max_xy);
      logic [2:0] eg[$];
      bit         ef[$];
      int         d[3];
      int         done_at[3];
      int         n_fin;
      int         ovr;
      logic [2:0] dn;
      d = '{d0, d1, d2};
      eg.push_back(3'b000); ef.push_back(1'b0);
      for (int i = 0; i < 3; i++) begin
         if (!req[i] || frz) begin
            done_at[i] = -1;
            eg.push_back(3'b000); ef.push_back(1'b0);
         end else begin
            done_at[i] = eg.size() + d[i];
            for (int c = 0; c <= d[i]; c++) begin
               eg.push_back(3'(1 << i)); ef.push_back(1'b0);
            end
         end
      end
      n_fin = eg.size();
      eg.push_back(3'b000); ef.push_back(1'b1);
      eg.push_back(3'b000); ef.push_back(1'b0);
      ovr = (ovr_at < 0) ? int'($urandom_range(n_fin, 1)) : ovr_at;

      for (int k = 0; k <= n_fin + 1; k++) begin
         if (k > 0) begin
            check_outputs(eg[k], (k <= n_fin), ef[k], (ovr > 0 && k == ovr + 1), 1'b0);
            if (max_xy && eg[k-1] == 3'b010) begin
               check_eq("max_x",    32'(bus.o_vga_x),      32'd159);
               check_eq("max_y",    32'(bus.o_vga_y),      32'd119);
               check_eq("max_col",  32'(bus.o_vga_colour), 32'd5);
            end
         end
         bus.i_frame_tick = (k == 0) || (ovr > 0 && k == ovr);
         bus.i_freeze     = (k == 0) ? frz : 1'($urandom);
         bus.i_req        = req;
         dn = 3'b000;
         for (int j = 0; j < 3; j++) begin
            if (k == done_at[j]) dn[j] = 1'b1;
            else if (!eg[k][j] && $urandom_range(3, 0) == 0) dn[j] = 1'b1;
         end
         bus.i_done = dn;
         drive_payload(eg[k], max_xy);
         @(posedge clk); #1;
      end
   endtask

   // Requester 0 never finishes; optionally the watchdog moves on to P1.
   // Reset then lands mid-phase and the aborted sequence must stay silent.
   task automatic reset_mid_phase();
      logic [2:0] g;
      for (int k = 0; k <= 24; k++) begin
         g = (k == 0) ? 3'b000 : ((k <= HOLD) ? 3'b001 : 3'b010);
         if (k > 0) check_outputs(g, 1'b1, 1'b0, 1'b0, (k == HOLD + 1));
         bus.i_frame_tick = (k == 0);
         bus.i_freeze     = 1'b0;
         bus.i_req        = 3'b011;
         bus.i_done       = {1'($urandom), 2'b00};
         drive_payload(g, 1'b0);
         @(posedge clk); #1;
      end
      bus.i_frame_tick = 1'b0;
      #2 reset = 1'b1;
      #1;
      m_vx = '0; m_vy = '0; m_vc = '0; m_vp = 1'b0;
      check_eq("rst_grant", 32'(bus.o_grant),    32'd0);
      check_eq("rst_plot",  32'(bus.o_vga_plot), 32'd0);
      check_eq("rst_busy",  32'(bus.o_busy),     32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check_outputs(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
         drive_payload(3'b000, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b1;
      bus.i_frame_tick = 1'b0;
      bus.i_freeze     = 1'b0;
      bus.i_req        = '0;
      bus.i_done       = '0;
      bus.i_x_in       = '0;
      bus.i_y_in       = '0;
      bus.i_colour_in  = '0;
      bus.i_plot_in    = '0;
      m_vx = '0; m_vy = '0; m_vc = '0; m_vp = 1'b0;
      #2;
      check_eq("async_rst_grant", 32'(bus.o_grant),    32'd0);
      check_eq("async_rst_plot",  32'(bus.o_vga_plot), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_frame(3'b111, 1'b0, 4, 4, 4, 0, 1'b0);
      run_frame(3'b010, 1'b0, 3, 0, 0, 0, 1'b0);
      run_frame(3'b111, 1'b1, 2, 2, 2, 0, 1'b0);
      run_frame(3'b111, 1'b0, 4, 4, 4, 7, 1'b0);
      run_frame(3'b111, 1'b0, 4, 4, 4, 5, 1'b0);
      run_frame(3'b010, 1'b0, 0, 2, 0, 0, 1'b1);
      run_frame(3'b101, 1'b0, 0, 0, 0, -1, 1'b0);
      for (int n = 0; n < 25; n++) begin
         run_frame(3'($urandom), ($urandom_range(4, 0) == 0),
                   int'($urandom_range(6, 0)), int'($urandom_range(6, 0)),
                   int'($urandom_range(6, 0)),
                   ($urandom_range(1, 0) == 1) ? -1 : 0, 1'($urandom));
      end
      reset_mid_phase();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
